// File: rtl/mips_core_pkg.sv
// Shared MIPS core definitions: per-thread scheduling state and thread-count limit.
package mips_core_pkg;

  localparam int MAX_THREADS = 16;

  typedef enum logic [1:0] {
    TS_READY    = 2'd0,
    TS_BR_WAIT  = 2'd1,
    TS_MEM_WAIT = 2'd2,
    TS_DONE     = 2'd3
  } ThreadState;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first: returns the set bit of i_mask nearest
// at or after i_start, wrapping modulo N.
module rr_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_start,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  int w_best;
  int w_dist;

  // Rank every candidate by its wrapped distance from the start pointer.
  always_comb begin
    w_best = N;
    w_dist = 0;
    o_idx  = '0;
    for (int p = 0; p < N; p++) begin
      w_dist = (p - int'(i_start) + N) % N;
      if (i_mask[p] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = W'(p);
      end
    end
    o_found = (w_best < N);
  end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained multithreading fetch scheduler with per-thread branch/miss tracking.
// Optional per-thread grant counters are built when THREAD_SCHED_STATS_EN is defined.
module thread_scheduler
  import mips_core_pkg::*;
#(
  parameter int NUM_THREADS = 4,
  parameter int TID_W       = $clog2(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_stall,
  input  logic                     i_dec_valid,
  input  logic                     i_dec_is_branch_jump,
  input  logic [TID_W-1:0]         i_dec_thread_id,
  input  logic                     i_ex_resolve_valid,
  input  logic [TID_W-1:0]         i_ex_thread_id,
  input  logic                     i_mem_miss_valid,
  input  logic [TID_W-1:0]         i_mem_miss_thread_id,
  input  logic                     i_mem_done_valid,
  input  logic [TID_W-1:0]         i_mem_done_thread_id,
  input  logic                     i_thread_done_valid,
  input  logic [TID_W-1:0]         i_thread_done_id,
  output logic                     o_fetch_valid,
  output logic [TID_W-1:0]         o_thread_id,
  output logic                     o_all_done,
  output logic [NUM_THREADS*32-1:0] o_grant_count
);

  logic [NUM_THREADS-1:0] w_ready;
  logic [NUM_THREADS-1:0] w_done;
  logic [TID_W-1:0]       w_start;
  logic [TID_W-1:0]       w_pick_idx;
  logic                   w_pick_found;

  logic                   r_fetch_valid;
  logic [TID_W-1:0]       r_thread_id;
  logic [TID_W-1:0]       r_last_grant;
  logic                   r_all_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
      ThreadState r_state;
      ThreadState w_state_next;
      logic       r_br_pending;
      logic       w_br_next;
      logic       w_hit_done;
      logic       w_hit_miss;
      logic       w_hit_mdone;
      logic       w_hit_res;
      logic       w_hit_dec;

      // Out-of-range ids never match any thread index, so they drop out here.
      assign w_hit_done  = i_thread_done_valid && (i_thread_done_id == TID_W'(gi));
      assign w_hit_miss  = i_mem_miss_valid && (i_mem_miss_thread_id == TID_W'(gi));
      assign w_hit_mdone = i_mem_done_valid && (i_mem_done_thread_id == TID_W'(gi));
      assign w_hit_res   = i_ex_resolve_valid && (i_ex_thread_id == TID_W'(gi));
      assign w_hit_dec   = i_dec_valid && i_dec_is_branch_jump &&
                           (i_dec_thread_id == TID_W'(gi));

      always_comb begin
        w_state_next = r_state;
        w_br_next    = r_br_pending;
        if (w_hit_done) begin
          w_state_next = TS_DONE;
        end else begin
          unique case (r_state)
            TS_READY: begin
              if (w_hit_miss) begin
                w_state_next = TS_MEM_WAIT;
              end else if (w_hit_dec) begin
                w_state_next = TS_BR_WAIT;
                w_br_next    = 1'b1;
              end
            end
            TS_BR_WAIT: begin
              if (w_hit_miss) begin
                w_state_next = TS_MEM_WAIT;
              end else if (w_hit_res) begin
                w_state_next = TS_READY;
                w_br_next    = 1'b0;
              end
            end
            TS_MEM_WAIT: begin
              // A refill outranks a same-cycle resolve.
              if (w_hit_mdone) begin
                w_state_next = r_br_pending ? TS_BR_WAIT : TS_READY;
              end else if (w_hit_res) begin
                w_br_next = 1'b0;
              end
            end
            default: ;
          endcase
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_state      <= TS_READY;
          r_br_pending <= 1'b0;
        end else begin
          r_state      <= w_state_next;
          r_br_pending <= w_br_next;
        end
      end

      assign w_ready[gi] = (r_state == TS_READY);
      assign w_done[gi]  = (r_state == TS_DONE);
    end
  endgenerate

  assign w_start = (r_last_grant == TID_W'(NUM_THREADS - 1)) ? '0
                                                             : r_last_grant + TID_W'(1);

  rr_picker #(
    .N (NUM_THREADS),
    .W (TID_W)
  ) u_picker (
    .i_mask  (w_ready),
    .i_start (w_start),
    .o_found (w_pick_found),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_valid <= 1'b0;
      r_thread_id   <= '0;
      r_last_grant  <= TID_W'(NUM_THREADS - 1);
      r_all_done    <= 1'b0;
    end else begin
      r_all_done <= &w_done;
      if (!i_stall) begin
        r_fetch_valid <= w_pick_found;
        if (w_pick_found) begin
          r_thread_id  <= w_pick_idx;
          r_last_grant <= w_pick_idx;
        end
      end
    end
  end

  assign o_fetch_valid = r_fetch_valid;
  assign o_thread_id   = r_thread_id;
  assign o_all_done    = r_all_done;

`ifdef THREAD_SCHED_STATS_EN
  generate
    for (gi = 0; gi < NUM_THREADS; gi++) begin : g_stats
      logic [31:0] r_count;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_count <= '0;
        end else if (r_fetch_valid && !i_stall && (r_thread_id == TID_W'(gi))) begin
          r_count <= r_count + 32'd1;
        end
      end
      assign o_grant_count[gi*32 +: 32] = r_count;
    end
  endgenerate
`else
  assign o_grant_count = '0;
`endif

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler with a cycle-level reference model of the
// thread rules; optional counter checks follow THREAD_SCHED_STATS_EN.
module tb_thread_scheduler;

  localparam int N  = 4;
  localparam int TW = 2;

  localparam int S_RDY = 0, S_BR = 1, S_MEM = 2, S_DN = 3;
  localparam int K_NONE = 0, K_DEC = 1, K_RES = 2, K_MISS = 3, K_MDONE = 4,
                 K_DONE = 5, K_DONE_MISS = 6, K_RST = 7;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_stall = 1'b0;
  logic            i_dec_valid = 1'b0;
  logic            i_dec_is_branch_jump = 1'b0;
  logic [TW-1:0]   i_dec_thread_id = '0;
  logic            i_ex_resolve_valid = 1'b0;
  logic [TW-1:0]   i_ex_thread_id = '0;
  logic            i_mem_miss_valid = 1'b0;
  logic [TW-1:0]   i_mem_miss_thread_id = '0;
  logic            i_mem_done_valid = 1'b0;
  logic [TW-1:0]   i_mem_done_thread_id = '0;
  logic            i_thread_done_valid = 1'b0;
  logic [TW-1:0]   i_thread_done_id = '0;
  logic            o_fetch_valid;
  logic [TW-1:0]   o_thread_id;
  logic            o_all_done;
  logic [N*32-1:0] o_grant_count;

  int n_checks = 0;
  int n_fail   = 0;
  int row_no   = 0;
  bit model_on = 1'b0;

  thread_scheduler #(.NUM_THREADS(N)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_stall              (i_stall),
    .i_dec_valid          (i_dec_valid),
    .i_dec_is_branch_jump (i_dec_is_branch_jump),
    .i_dec_thread_id      (i_dec_thread_id),
    .i_ex_resolve_valid   (i_ex_resolve_valid),
    .i_ex_thread_id       (i_ex_thread_id),
    .i_mem_miss_valid     (i_mem_miss_valid),
    .i_mem_miss_thread_id (i_mem_miss_thread_id),
    .i_mem_done_valid     (i_mem_done_valid),
    .i_mem_done_thread_id (i_mem_done_thread_id),
    .i_thread_done_valid  (i_thread_done_valid),
    .i_thread_done_id     (i_thread_done_id),
    .o_fetch_valid        (o_fetch_valid),
    .o_thread_id          (o_thread_id),
    .o_all_done           (o_all_done),
    .o_grant_count        (o_grant_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (row %0d): got %0d, expected %0d", name, row_no, act, exp);
    end
  endtask

  // Reference model: thread states as plain ints, grant picked by scanning
  // forward from the previous grant.
  int          m_state [N];
  bit          m_brp   [N];
  int          m_last;
  bit          m_fv;
  int          m_tid;
  bit          m_ad;
  int unsigned m_cnt   [N];

  always @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < N; t++) begin
        m_state[t] = S_RDY;
        m_brp[t]   = 1'b0;
        m_cnt[t]   = 0;
      end
      m_last = N - 1;
      m_fv   = 1'b0;
      m_tid  = 0;
      m_ad   = 1'b0;
    end else begin
      int  old_state [N];
      bit  all_dn;
      for (int t = 0; t < N; t++) old_state[t] = m_state[t];
      if (m_fv && !i_stall) m_cnt[m_tid] = m_cnt[m_tid] + 1;
      all_dn = 1'b1;
      for (int t = 0; t < N; t++) if (old_state[t] != S_DN) all_dn = 1'b0;
      m_ad = all_dn;
      if (!i_stall) begin
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
          int t;
          t = (m_last + k) % N;
          if (!hit && old_state[t] == S_RDY) begin
            hit    = 1'b1;
            m_tid  = t;
            m_last = t;
          end
        end
        m_fv = hit;
      end
      for (int t = 0; t < N; t++) begin
        int s;
        bit b, h_dn, h_miss, h_md, h_res, h_dec;
        s      = m_state[t];
        b      = m_brp[t];
        h_dn   = i_thread_done_valid && (int'(i_thread_done_id) == t);
        h_miss = i_mem_miss_valid && (int'(i_mem_miss_thread_id) == t);
        h_md   = i_mem_done_valid && (int'(i_mem_done_thread_id) == t);
        h_res  = i_ex_resolve_valid && (int'(i_ex_thread_id) == t);
        h_dec  = i_dec_valid && i_dec_is_branch_jump && (int'(i_dec_thread_id) == t);
        // Highest-priority event that is legal in the current state wins.
        if (h_dn) s = S_DN;
        else if (h_miss && (s == S_RDY || s == S_BR)) s = S_MEM;
        else if (h_md && s == S_MEM) s = b ? S_BR : S_RDY;
        else if (h_res && s == S_BR) begin s = S_RDY; b = 1'b0; end
        else if (h_res && s == S_MEM) b = 1'b0;
        else if (h_dec && s == S_RDY) begin s = S_BR; b = 1'b1; end
        m_state[t] = s;
        m_brp[t]   = b;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("model_fetch_valid", o_fetch_valid, m_fv);
      chk("model_thread_id", o_thread_id, m_tid);
      chk("model_all_done", o_all_done, m_ad);
      for (int t = 0; t < N; t++) begin
`ifdef THREAD_SCHED_STATS_EN
        chk($sformatf("model_count%0d", t), o_grant_count[t*32 +: 32], m_cnt[t]);
`else
        chk($sformatf("model_count%0d", t), o_grant_count[t*32 +: 32], 0);
`endif
      end
    end
  end

  task automatic clear_inputs();
    rst                  = 1'b0;
    i_stall              = 1'b0;
    i_dec_valid          = 1'b0;
    i_dec_is_branch_jump = 1'b0;
    i_ex_resolve_valid   = 1'b0;
    i_mem_miss_valid     = 1'b0;
    i_mem_done_valid     = 1'b0;
    i_thread_done_valid  = 1'b0;
  endtask

  task automatic row(int kind, int tid, bit stall, bit efv, int etid, bit ead);
    row_no++;
    i_stall = stall;
    case (kind)
      K_DEC:   begin i_dec_valid = 1'b1; i_dec_is_branch_jump = 1'b1; i_dec_thread_id = TW'(tid); end
      K_RES:   begin i_ex_resolve_valid = 1'b1; i_ex_thread_id = TW'(tid); end
      K_MISS:  begin i_mem_miss_valid = 1'b1; i_mem_miss_thread_id = TW'(tid); end
      K_MDONE: begin i_mem_done_valid = 1'b1; i_mem_done_thread_id = TW'(tid); end
      K_DONE:  begin i_thread_done_valid = 1'b1; i_thread_done_id = TW'(tid); end
      K_DONE_MISS: begin
        i_thread_done_valid = 1'b1; i_thread_done_id = TW'(tid);
        i_mem_miss_valid = 1'b1; i_mem_miss_thread_id = TW'(tid);
      end
      K_RST: begin
        rst = 1'b1;
        i_mem_miss_valid = 1'b1; i_mem_miss_thread_id = TW'(tid);
      end
      default: ;
    endcase
    @(posedge clk);
    #1;
    clear_inputs();
    chk("row_fetch_valid", o_fetch_valid, efv);
    chk("row_thread_id", o_thread_id, etid);
    chk("row_all_done", o_all_done, ead);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_on = 1'b1;
    chk("reset_fetch_valid", o_fetch_valid, 0);
    chk("reset_thread_id", o_thread_id, 0);
    chk("reset_all_done", o_all_done, 0);
    rst = 1'b0;

    // Free-running round robin.
    row(K_NONE, 0, 0, 1, 0, 0);
    row(K_NONE, 0, 0, 1, 1, 0);
    row(K_NONE, 0, 0, 1, 2, 0);
    row(K_NONE, 0, 0, 1, 3, 0);
    row(K_NONE, 0, 0, 1, 0, 0);
    // Branch on thread 1 blocks it until resolve.
    row(K_DEC,  1, 0, 1, 1, 0);
    row(K_NONE, 0, 0, 1, 2, 0);
    row(K_NONE, 0, 0, 1, 3, 0);
    row(K_NONE, 0, 0, 1, 0, 0);
    row(K_NONE, 0, 0, 1, 2, 0);
    row(K_RES,  1, 0, 1, 3, 0);
    row(K_NONE, 0, 0, 1, 0, 0);
    row(K_NONE, 0, 0, 1, 1, 0);
    // Thread 2: branch, miss, resolve, refill -> ready.
    row(K_DEC,   2, 0, 1, 2, 0);
    row(K_MISS,  2, 0, 1, 3, 0);
    row(K_RES,   2, 0, 1, 0, 0);
    row(K_MDONE, 2, 0, 1, 1, 0);
    row(K_NONE,  0, 0, 1, 2, 0);
    // Thread 2: branch, miss, refill before resolve -> back to branch wait.
    row(K_DEC,   2, 0, 1, 3, 0);
    row(K_MISS,  2, 0, 1, 0, 0);
    row(K_MDONE, 2, 0, 1, 1, 0);
    row(K_NONE,  0, 0, 1, 3, 0);
    row(K_NONE,  0, 0, 1, 0, 0);
    row(K_NONE,  0, 0, 1, 1, 0);
    row(K_NONE,  0, 0, 1, 3, 0);
    row(K_RES,   2, 0, 1, 0, 0);
    row(K_NONE,  0, 0, 1, 1, 0);
    row(K_NONE,  0, 0, 1, 2, 0);
    row(K_NONE,  0, 0, 1, 3, 0);
    // Stall five cycles with thread 3 granted.
    for (int i = 0; i < 5; i++) row(K_NONE, 0, 1, 1, 3, 0);
    row(K_NONE, 0, 0, 1, 0, 0);
    // Threads finish; thread 0 gets done and miss together.
    row(K_DONE_MISS, 0, 0, 1, 1, 0);
    row(K_NONE, 0, 0, 1, 2, 0);
    row(K_NONE, 0, 0, 1, 3, 0);
    row(K_NONE, 0, 0, 1, 1, 0);
    row(K_DONE, 1, 0, 1, 2, 0);
    row(K_DONE, 2, 0, 1, 3, 0);
    row(K_DONE, 3, 0, 1, 3, 0);
    row(K_NONE, 0, 0, 0, 3, 1);
    row(K_NONE, 0, 0, 0, 3, 1);
    // Reset overriding a same-cycle miss, then 40 counted grants.
    row(K_RST, 1, 0, 0, 0, 0);
    for (int i = 0; i < 41; i++) row(K_NONE, 0, 0, 1, i % N, 0);
    for (int t = 0; t < N; t++) begin
`ifdef THREAD_SCHED_STATS_EN
      chk($sformatf("final_count%0d", t), o_grant_count[t*32 +: 32], 10);
`else
      chk($sformatf("final_count%0d", t), o_grant_count[t*32 +: 32], 0);
`endif
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
# thread_scheduler

Fine-grained multithreading scheduler for the MIPS core front end. Each cycle it selects which hardware thread's PC is fetched, and therefore which thread the decoder sees. It tracks per-thread state from decode, execute and memory events, and stops issuing for a thread that has an unresolved branch/jump, an outstanding cache miss, or has finished. Eligible threads are granted round-robin, and the registered `o_thread_id` drives the `thread_id` field carried through `pc_ifc` and `decoder_output_ifc`.

## Interface
Parameters:
- `NUM_THREADS`, default 4: hardware threads, from 2 to 16.
- `TID_W`, default `$clog2(NUM_THREADS)`: thread id width.

Ports:
- `clk` input, 1 bit: core clock.
- `rst` input, 1 bit: reset; synchronous, active-high.
- `i_stall` input, 1 bit: front-end hazard stall; the current grant is held.
- `i_dec_valid` input, 1 bit: decoder output valid.
- `i_dec_is_branch_jump` input, 1 bit: decoded instruction is a branch or jump.
- `i_dec_thread_id` input, `TID_W` bits: thread of the decoded instruction.
- `i_ex_resolve_valid` input, 1 bit: a branch/jump resolved in EX.
- `i_ex_thread_id` input, `TID_W` bits: thread of the resolved branch.
- `i_mem_miss_valid` input, 1 bit: D-cache or I-cache miss started.
- `i_mem_miss_thread_id` input, `TID_W` bits: thread that missed.
- `i_mem_done_valid` input, 1 bit: miss refill complete.
- `i_mem_done_thread_id` input, `TID_W` bits: thread whose miss completed.
- `i_thread_done_valid` input, 1 bit: MTC0 DONE, PASS or FAIL executed.
- `i_thread_done_id` input, `TID_W` bits: thread that finished.
- `o_fetch_valid` output, 1 bit: a thread is granted this cycle.
- `o_thread_id` output, `TID_W` bits: granted thread.
- `o_all_done` output, 1 bit: every thread is in DONE.
- `o_grant_count` output, `NUM_THREADS*32` bits: per-thread grant counters (see Configuration).

## Operation
- Per-thread state uses `ThreadState`: TS_READY, TS_BR_WAIT, TS_MEM_WAIT, TS_DONE. Each thread also has a `br_pending` flag.
- Each thread evaluates its own events every cycle. When several events hit the same thread, priority is thread_done > mem_miss > mem_done > ex_resolve > dec branch.
- TS_DONE is sticky until `rst`.
- TS_READY goes to TS_BR_WAIT on a decoded branch/jump and sets `br_pending`.
- TS_READY or TS_BR_WAIT goes to TS_MEM_WAIT on a miss. `br_pending` is retained.
- In TS_MEM_WAIT, a resolve clears `br_pending`. On mem_done the thread goes to TS_BR_WAIT if `br_pending` is set, otherwise to TS_READY.
- TS_BR_WAIT goes to TS_READY on resolve and clears `br_pending`.
- An event that does not apply to the thread's current state is ignored; for example, resolve in TS_READY or mem_done in TS_BR_WAIT.
- Arbitration: search starts at `last_grant+1` modulo `NUM_THREADS` and picks the first thread in TS_READY. The search uses the states held in registers at the start of the cycle, not the next-state values.
- If no thread is in TS_READY, `o_fetch_valid`=0 and `o_thread_id` holds its last value.
- `o_all_done` is high when all threads are in TS_DONE.

## Timing
- Reset values:
  - all threads TS_READY, `br_pending`=0;
  - `last_grant`=`NUM_THREADS-1`, so the first grant goes to thread 0;
  - `o_fetch_valid`=0, `o_thread_id`=0, `o_all_done`=0, counters=0.
- All outputs are registered. An event sampled at edge N changes state at edge N. The resulting grant change appears after edge N+1.
- `i_stall`=1 holds `o_fetch_valid`, `o_thread_id` and `last_grant`. State updates continue during a stall.
- `rst` asserted mid-miss or mid-branch overrides all events in that cycle.
- Thread id inputs are only meaningful while their valid is high. Ids at or above `NUM_THREADS` are ignored.

## Configuration
- `THREAD_SCHED_STATS_EN` defined: one 32-bit counter per thread increments on every cycle with `o_fetch_valid`=1, `i_stall`=0 and that thread granted. Counters wrap at 2^32.
- `THREAD_SCHED_STATS_EN` not defined: no counter logic is generated, and `o_grant_count` is tied to 0.

## Structure
- `mips_core_pkg` holds `ThreadState` and `MAX_THREADS` (16).
- Sub-module `rr_picker`: combinational round-robin find-first over a ready mask and a start pointer. It returns `found` and `idx`.

## Test plan
- Reset with 4 threads, no events: `o_thread_id` cycles 0,1,2,3,0…, with `o_fetch_valid`=1 from the first cycle after reset.
- Decode branch for thread 1: thread 1 is skipped (grants 2,3,0,2,…) until `i_ex_resolve_valid` for thread 1, then it is granted again within 4 cycles.
- Miss on thread 2 while it is in TS_BR_WAIT, then resolve, then mem_done: the thread goes to TS_READY. Repeating with mem_done before resolve returns it to TS_BR_WAIT.
- Same-cycle thread_done and mem_miss on thread 0: the thread enters TS_DONE and is never granted again. After all 4 threads are done, `o_all_done`=1 and `o_fetch_valid`=0.
- `i_stall` held for 5 cycles while thread 3 is granted: `o_thread_id` stays 3. After release the next grant is thread 0.
- With `THREAD_SCHED_STATS_EN`, 40 unstalled cycles with 4 threads ready: every counter equals 10.
